// File: rtl/dcache_wb_if.sv
// Processor load/store-drain and memory request signals of the write-back data cache.
// The cache uses the slave view; the processor/memory environment uses the master view.
interface dcache_wb_if;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        dhit;
    logic [31:0] ld_data;
    logic        busy;

    logic        sb_valid;
    logic [31:0] sb_addr;
    logic [31:0] sb_data;
    logic        sb_ready;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport slave (
        input  ld_req, ld_addr, sb_valid, sb_addr, sb_data, mem_ready, mem_rdata,
        output dhit, ld_data, busy, sb_ready, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output ld_req, ld_addr, sb_valid, sb_addr, sb_data, mem_ready, mem_rdata,
        input  dhit, ld_data, busy, sb_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped write-back data cache, one word per line, fed by the store buffer.
// Define DCACHE_WRITE_ALLOCATE_EN to allocate on store misses; otherwise store misses write through.
module dcache_wb #(
    parameter int unsigned INDEX_BITS = 4
) (
    input logic        clk,
    input logic        rst_n,
    dcache_wb_if.slave bus
);
    localparam int unsigned LINES = 1 << INDEX_BITS;
    localparam int unsigned TAG_W = 32 - INDEX_BITS - 2;

    typedef logic [INDEX_BITS-1:0] idx_t;
    typedef logic [TAG_W-1:0]      tag_t;
    typedef enum logic [1:0] {StIdle, StWb, StFill, StWt} state_e;

    state_e state_q, state_d;
    logic   svc_load_q, svc_load_d;
    idx_t   svc_idx_q, svc_idx_d;
    tag_t   svc_tag_q, svc_tag_d;

    logic [LINES-1:0] valid_q, dirty_q;
    tag_t             tag_q  [LINES];
    logic [31:0]      data_q [LINES];

    logic        line_we, tag_we, valid_set, dirty_we, dirty_val;
    idx_t        wr_idx;
    tag_t        wr_tag;
    logic [31:0] wr_data;

    idx_t ld_idx, sb_idx;
    tag_t ld_tag, sb_tag;
    logic ld_hit, sb_hit;

    assign ld_idx = bus.ld_addr[INDEX_BITS+1:2];
    assign ld_tag = bus.ld_addr[31:INDEX_BITS+2];
    assign sb_idx = bus.sb_addr[INDEX_BITS+1:2];
    assign sb_tag = bus.sb_addr[31:INDEX_BITS+2];
    assign ld_hit = valid_q[ld_idx] && (tag_q[ld_idx] == ld_tag);
    assign sb_hit = valid_q[sb_idx] && (tag_q[sb_idx] == sb_tag);

    // Arrays update only at the clock edge, so a same-cycle store shows the old word here.
    assign bus.dhit    = (state_q == StIdle) && bus.ld_req && ld_hit;
    assign bus.ld_data = data_q[ld_idx];
    assign bus.busy    = (state_q != StIdle);

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.ld_addr[1:0], bus.sb_addr[1:0]};

    always_comb begin
        state_d       = state_q;
        svc_load_d    = svc_load_q;
        svc_idx_d     = svc_idx_q;
        svc_tag_d     = svc_tag_q;
        bus.sb_ready  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        line_we       = 1'b0;
        tag_we        = 1'b0;
        valid_set     = 1'b0;
        dirty_we      = 1'b0;
        dirty_val     = 1'b0;
        wr_idx        = svc_idx_q;
        wr_tag        = svc_tag_q;
        wr_data       = bus.mem_rdata;

        unique case (state_q)
            StIdle: begin
                if (bus.ld_req && !ld_hit) begin
                    svc_load_d = 1'b1;
                    svc_idx_d  = ld_idx;
                    svc_tag_d  = ld_tag;
                    state_d    = (valid_q[ld_idx] && dirty_q[ld_idx]) ? StWb : StFill;
                end else if (bus.sb_valid) begin
                    wr_idx  = sb_idx;
                    wr_tag  = sb_tag;
                    wr_data = bus.sb_data;
                    if (sb_hit) begin
                        line_we      = 1'b1;
                        dirty_we     = 1'b1;
                        dirty_val    = 1'b1;
                        bus.sb_ready = 1'b1;
                    end
`ifdef DCACHE_WRITE_ALLOCATE_EN
                    else if (!(valid_q[sb_idx] && dirty_q[sb_idx])) begin
                        line_we      = 1'b1;
                        tag_we       = 1'b1;
                        valid_set    = 1'b1;
                        dirty_we     = 1'b1;
                        dirty_val    = 1'b1;
                        bus.sb_ready = 1'b1;
                    end else begin
                        // Clean the victim first; the store retries from idle afterwards.
                        svc_load_d = 1'b0;
                        svc_idx_d  = sb_idx;
                        svc_tag_d  = sb_tag;
                        state_d    = StWb;
                    end
`else
                    else begin
                        state_d = StWt;
                    end
`endif
                end
            end
            StWb: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {tag_q[svc_idx_q], svc_idx_q, 2'b00};
                bus.mem_wdata = data_q[svc_idx_q];
                if (bus.mem_ready) begin
                    dirty_we  = 1'b1;
                    dirty_val = 1'b0;
                    state_d   = svc_load_q ? StFill : StIdle;
                end
            end
            StFill: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {svc_tag_q, svc_idx_q, 2'b00};
                if (bus.mem_ready) begin
                    line_we   = 1'b1;
                    tag_we    = 1'b1;
                    valid_set = 1'b1;
                    dirty_we  = 1'b1;
                    dirty_val = 1'b0;
                    state_d   = StIdle;
                end
            end
            StWt: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {bus.sb_addr[31:2], 2'b00};
                bus.mem_wdata = bus.sb_data;
                bus.sb_ready  = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            svc_load_q <= 1'b0;
            svc_idx_q  <= '0;
            svc_tag_q  <= '0;
            valid_q    <= '0;
            dirty_q    <= '0;
        end else begin
            state_q    <= state_d;
            svc_load_q <= svc_load_d;
            svc_idx_q  <= svc_idx_d;
            svc_tag_q  <= svc_tag_d;
            if (valid_set) valid_q[wr_idx] <= 1'b1;
            if (dirty_we)  dirty_q[wr_idx] <= dirty_val;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we) data_q[wr_idx] <= wr_data;
        if (tag_we)  tag_q[wr_idx]  <= wr_tag;
    end
endmodule

// File: tb/tb_dcache_wb.sv
// Randomized scoreboard bench for dcache_wb: a line-state model plus golden memory predicts
// load data and memory traffic; monitors compare whenever the cache responds.
module tb_dcache_wb;
    localparam int LINES = 16;
`ifdef DCACHE_WRITE_ALLOCATE_EN
    localparam bit ALLOC = 1'b1;
`else
    localparam bit ALLOC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dcache_wb_if bus();
    dcache_wb #(.INDEX_BITS(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {bit we; logic [31:0] addr; logic [31:0] wdata;} mem_txn_t;
    typedef struct {logic [31:0] data; bit miss;} ld_exp_t;
    mem_txn_t exp_mem[$];
    ld_exp_t  exp_ld[$];

    int n_checks = 0;
    int n_err = 0;

    bit          m_valid [LINES];
    bit          m_dirty [LINES];
    logic [31:0] m_tag   [LINES];
    logic [31:0] golden  [logic [31:0]];
    logic [31:0] mem     [logic [31:0]];
    bit          mem_hold = 1'b0;
    int unsigned fill_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: got no completion within bound, required completion", name);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] w);
        return mem.exists(w) ? mem[w] : ((w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
    endfunction

    function automatic logic [31:0] gold_rd(input logic [31:0] w);
        return golden.exists(w) ? golden[w] : mem_rd(w);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) & 32'hF);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> 6;
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
    endfunction

    function automatic logic [31:0] victim_addr(input int i);
        return (m_tag[i] << 6) | (32'(i) << 2);
    endfunction

    task automatic model_load(input logic [31:0] a);
        int i;
        bit miss;
        i = idx_of(a);
        miss = !model_hit(a);
        if (miss) begin
            if (m_valid[i] && m_dirty[i])
                exp_mem.push_back('{1'b1, victim_addr(i), gold_rd(victim_addr(i) >> 2)});
            exp_mem.push_back('{1'b0, a & ~32'h3, 32'h0});
            m_valid[i] = 1'b1;
            m_dirty[i] = 1'b0;
            m_tag[i]   = tag_of(a);
        end
        exp_ld.push_back('{gold_rd(a >> 2), miss});
    endtask

    function automatic bit store_fast(input logic [31:0] a);
        int i;
        i = idx_of(a);
        return model_hit(a) || (ALLOC && !(m_valid[i] && m_dirty[i]));
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] d);
        int i;
        i = idx_of(a);
        if (model_hit(a)) begin
            m_dirty[i] = 1'b1;
        end else if (ALLOC) begin
            if (m_valid[i] && m_dirty[i])
                exp_mem.push_back('{1'b1, victim_addr(i), gold_rd(victim_addr(i) >> 2)});
            m_valid[i] = 1'b1;
            m_dirty[i] = 1'b1;
            m_tag[i]   = tag_of(a);
        end else begin
            exp_mem.push_back('{1'b1, a & ~32'h3, d});
        end
        golden[a >> 2] = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < LINES; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        golden.delete();
    endtask

    // Memory responder and memory-traffic scoreboard.
    initial begin : mem_side
        int       wait_cnt;
        mem_txn_t t;
        logic [31:0] w;
        wait_cnt = 3;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_ready = 1'b0;
            if (rst_n && bus.mem_req && !mem_hold) begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                end else begin
                    w = bus.mem_addr >> 2;
                    if (exp_mem.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL mem_unexpected: got we=%0b addr=%h, required no request",
                                 bus.mem_we, bus.mem_addr);
                    end else begin
                        t = exp_mem.pop_front();
                        check("mem_we", 32'(bus.mem_we), 32'(t.we));
                        check("mem_addr", bus.mem_addr, t.addr);
                        if (t.we) check("mem_wdata", bus.mem_wdata, t.wdata);
                    end
                    if (bus.mem_we) begin
                        mem[w] = bus.mem_wdata;
                    end else begin
                        bus.mem_rdata = mem_rd(w);
                        fill_cyc = cyc;
                    end
                    bus.mem_ready = 1'b1;
                    wait_cnt = $urandom_range(0, 3);
                end
            end
        end
    end

    // Load-response monitor.
    always @(negedge clk) begin : ld_mon
        ld_exp_t e;
        if (rst_n && bus.dhit) begin
            if (exp_ld.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL ld_unexpected: got dhit data=%h, required no hit", bus.ld_data);
            end else begin
                e = exp_ld.pop_front();
                check("ld_data", bus.ld_data, e.data);
                if (e.miss) check("dhit_latency", cyc, fill_cyc + 1);
            end
        end
    end

    task automatic do_op(input bit do_ld, input logic [31:0] la,
                         input bit do_st, input logic [31:0] sa, input logic [31:0] sd);
        bit exp_dhit, exp_sbr, ld_pend, sb_pend, ld_fin, sb_fin;
        int cnt;
        exp_dhit = 1'b0;
        exp_sbr  = 1'b0;
        if (do_ld) begin
            exp_dhit = model_hit(la);
            model_load(la);
        end
        if (do_st) begin
            exp_sbr = (!do_ld || exp_dhit) && store_fast(sa);
            model_store(sa, sd);
        end
        bus.ld_req   = do_ld;
        bus.ld_addr  = la;
        bus.sb_valid = do_st;
        bus.sb_addr  = sa;
        bus.sb_data  = sd;
        ld_pend = do_ld;
        sb_pend = do_st;
        cnt = 0;
        while ((ld_pend || sb_pend) && cnt < 400) begin
            @(negedge clk);
            if (cnt == 0 && do_ld) check("dhit_first", 32'(bus.dhit), 32'(exp_dhit));
            if (cnt == 0 && do_st) check("sb_ready_first", 32'(bus.sb_ready), 32'(exp_sbr));
            ld_fin = ld_pend && bus.dhit;
            sb_fin = sb_pend && bus.sb_ready;
            @(posedge clk);
            #1;
            if (ld_fin) begin
                bus.ld_req = 1'b0;
                ld_pend = 1'b0;
            end
            if (sb_fin) begin
                bus.sb_valid = 1'b0;
                sb_pend = 1'b0;
            end
            cnt++;
        end
        if (ld_pend || sb_pend) begin
            fail_now("op_timeout");
            bus.ld_req   = 1'b0;
            bus.sb_valid = 1'b0;
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2)
             | 32'($urandom_range(0, 3));
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bit seen;
        int kind;
        rst_n = 1'b0;
        bus.ld_req = 1'b0;
        bus.ld_addr = '0;
        bus.sb_valid = 1'b0;
        bus.sb_addr = '0;
        bus.sb_data = '0;
        model_reset();
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_dhit", 32'(bus.dhit), 0);
        check("rst_mem_req", 32'(bus.mem_req), 0);
        check("rst_mem_we", 32'(bus.mem_we), 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_sb_ready", 32'(bus.sb_ready), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        mem[32'h40 >> 2] = 32'hDEAD_BEEF;
        do_op(1'b1, 32'h40, 1'b0, 0, 0);                       // fill, no write-back
        do_op(1'b0, 0, 1'b1, 32'h40, 32'h11);                  // store hit
        do_op(1'b1, 32'h40, 1'b0, 0, 0);
        do_op(1'b1, 32'h440, 1'b0, 0, 0);                      // dirty eviction
        do_op(1'b1, 32'h440, 1'b1, 32'h440, 32'h22);           // same-cycle: old word
        do_op(1'b1, 32'h440, 1'b0, 0, 0);
        do_op(1'b0, 0, 1'b1, 32'h840, 32'h33);                 // store miss, dirty victim
        do_op(1'b1, 32'h840, 1'b0, 0, 0);

        for (int n = 0; n < 160; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4)      do_op(1'b1, rnd_addr(), 1'b0, 0, 0);
            else if (kind < 8) do_op(1'b0, 0, 1'b1, rnd_addr(), $urandom);
            else               do_op(1'b1, rnd_addr(), 1'b1, rnd_addr(), $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        // Reset while a fill is outstanding.
        do_op(1'b1, 32'h80, 1'b0, 0, 0);
        mem_hold = 1'b1;
        bus.ld_req = 1'b1;
        bus.ld_addr = 32'h180;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.mem_req;
        end
        check("fill_req_seen", 32'(seen), 1);
        check("fill_req_read", 32'(bus.mem_we), 0);
        rst_n = 1'b0;
        bus.ld_req = 1'b0;
        #1;
        check("midrst_mem_req", 32'(bus.mem_req), 0);
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_mem_addr", bus.mem_addr, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_hold = 1'b0;
        @(posedge clk);
        #1;
        do_op(1'b1, 32'h80, 1'b0, 0, 0);                       // previously valid, now misses

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("exp_mem_empty", 32'(exp_mem.size()), 0);
        check("exp_ld_empty", 32'(exp_ld.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
